// File: rtl/z80_io_responder_if.sv
// Z80 I/O bus bundle shared by the CPU side (master) and the peripheral (slave).
// Carries the address/data/control strobes in, and the read data/handshake outputs back.
interface z80_io_responder_if;
  logic [15:0] A;
  logic [7:0]  di;
  logic        m1_n;
  logic        mreq_n;
  logic        iorq_n;
  logic        rd_n;
  logic        wr_n;
  logic [7:0]  dout;
  logic        doe;
  logic        wait_n;
  logic        int_n;

  modport master (
    output A, di, m1_n, mreq_n, iorq_n, rd_n, wr_n,
    input  dout, doe, wait_n, int_n
  );

  modport slave (
    input  A, di, m1_n, mreq_n, iorq_n, rd_n, wr_n,
    output dout, doe, wait_n, int_n
  );
endinterface

// File: rtl/z80_io_responder.sv
// Z80 I/O-mapped peripheral: scratch, IM2 vector, ID, CTRL/STATUS interrupt logic.
// Define Z80_IO_RESPONDER_TIMER_EN to build the 16-bit auto-reload down-counter.
module z80_io_responder #(
  parameter logic [7:0]  BASE_PORT   = 8'h40,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              irq_in,
  z80_io_responder_if.slave bus
);
  localparam logic [2:0] LP_WAIT = 3'(WAIT_STATES);
  localparam logic [7:0] LP_ID   = 8'h5A;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IO,
    ST_ACK
  } state_t;

  state_t      r_state;
  state_t      w_nextState;

  logic        w_sel;
  logic        w_ackCycle;
  logic        w_ioStart;
  logic        w_ackStart;
  logic        w_doe;
  logic        w_commit;
  logic        w_irqRise;
  logic        w_timerTick;
  logic        w_timerEn;
  logic [15:0] w_reload;
  logic [7:0]  w_rdData;
  logic [1:0]  w_stSet;
  logic [1:0]  w_stClr;
  logic        w_unused;

  logic [2:0]  r_waitCnt;
  logic [2:0]  r_addr;
  logic        r_wrDone;
  logic        r_irqPrev;
  logic        r_irqEn;
  logic        r_intN;
  logic [7:0]  r_scratch0;
  logic [7:0]  r_scratch1;
  logic [7:0]  r_vector;
  logic [7:0]  r_dout;
  logic [1:0]  r_status;

  assign w_unused = ^bus.A[15:8];

  assign w_sel = ~bus.iorq_n & bus.m1_n & bus.mreq_n &
                 (bus.A[7:3] == BASE_PORT[7:3]) & (~bus.rd_n | ~bus.wr_n);
  assign w_ackCycle = ~bus.m1_n & ~bus.iorq_n;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A transaction stays open until iorq_n rises, so one long strobe is one access.
  always_comb begin
    w_nextState = r_state;
    w_ioStart   = 1'b0;
    w_ackStart  = 1'b0;
    w_doe       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sel) begin
          w_nextState = ST_IO;
          w_ioStart   = 1'b1;
        end else if (w_ackCycle) begin
          w_nextState = ST_ACK;
          w_ackStart  = 1'b1;
        end
      end
      ST_IO: begin
        w_doe = ~bus.rd_n & ~bus.iorq_n;
        if (bus.iorq_n) begin
          w_nextState = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_doe = ~bus.iorq_n;
        if (bus.iorq_n) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  assign w_commit = (r_state == ST_IO) & ~bus.iorq_n & ~bus.wr_n &
                    (r_waitCnt == 3'd0) & ~r_wrDone;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_waitCnt <= 3'd0;
      r_addr    <= 3'd0;
      r_wrDone  <= 1'b0;
    end else if (w_ioStart) begin
      r_waitCnt <= LP_WAIT;
      r_addr    <= bus.A[2:0];
      r_wrDone  <= 1'b0;
    end else begin
      if (bus.iorq_n) begin
        r_waitCnt <= 3'd0;
      end else if (r_waitCnt != 3'd0) begin
        r_waitCnt <= r_waitCnt - 3'd1;
      end
      if (w_commit) begin
        r_wrDone <= 1'b1;
      end
    end
  end

  always_comb begin
    w_rdData = 8'h00;
    case (bus.A[2:0])
      3'd0: w_rdData = r_scratch0;
      3'd1: w_rdData = r_scratch1;
      3'd2: w_rdData = w_reload[7:0];
      3'd3: w_rdData = w_reload[15:8];
      3'd4: w_rdData = {6'b000000, r_irqEn, w_timerEn};
      3'd5: w_rdData = {6'b000000, r_status};
      3'd6: w_rdData = r_vector;
      3'd7: w_rdData = LP_ID;
      default: w_rdData = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_dout <= 8'h00;
    end else if (w_ioStart && !bus.rd_n) begin
      r_dout <= w_rdData;
    end else if (w_ackStart) begin
      r_dout <= r_vector;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scratch0 <= 8'h00;
      r_scratch1 <= 8'h00;
      r_vector   <= 8'h00;
      r_irqEn    <= 1'b0;
    end else if (w_commit) begin
      case (r_addr)
        3'd0: r_scratch0 <= bus.di;
        3'd1: r_scratch1 <= bus.di;
        3'd4: r_irqEn    <= bus.di[1];
        3'd6: r_vector   <= bus.di;
        default: ;
      endcase
    end
  end

`ifdef Z80_IO_RESPONDER_TIMER_EN
  logic [15:0] r_reload;
  logic [15:0] r_tcnt;
  logic        r_timerEn;

  // Enabling from off reloads the count; otherwise it free-runs and reloads on zero.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_reload  <= 16'h0000;
      r_tcnt    <= 16'h0000;
      r_timerEn <= 1'b0;
    end else begin
      if (w_commit && r_addr == 3'd2) begin
        r_reload[7:0] <= bus.di;
      end
      if (w_commit && r_addr == 3'd3) begin
        r_reload[15:8] <= bus.di;
      end
      if (w_commit && r_addr == 3'd4) begin
        r_timerEn <= bus.di[0];
      end
      if (w_commit && r_addr == 3'd4 && bus.di[0] && !r_timerEn) begin
        r_tcnt <= r_reload;
      end else if (r_timerEn) begin
        r_tcnt <= (r_tcnt == 16'h0000) ? r_reload : (r_tcnt - 16'd1);
      end
    end
  end

  assign w_reload    = r_reload;
  assign w_timerEn   = r_timerEn;
  assign w_timerTick = r_timerEn & (r_tcnt == 16'h0000);
`else
  assign w_reload    = 16'h0000;
  assign w_timerEn   = 1'b0;
  assign w_timerTick = 1'b0;
`endif

  assign w_irqRise = irq_in & ~r_irqPrev;
  assign w_stSet   = {w_irqRise, w_timerTick};

  // An acknowledge retires only the lowest pending source; new set events always win.
  always_comb begin
    w_stClr = 2'b00;
    if (w_commit && r_addr == 3'd5) begin
      w_stClr = bus.di[1:0];
    end
    if (w_ackStart) begin
      if (r_status[0]) begin
        w_stClr[0] = 1'b1;
      end else if (r_status[1]) begin
        w_stClr[1] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_status  <= 2'b00;
      r_irqPrev <= 1'b0;
      r_intN    <= 1'b1;
    end else begin
      r_status  <= (r_status & ~w_stClr) | w_stSet;
      r_irqPrev <= irq_in;
      r_intN    <= ~(r_irqEn & (r_status[0] | r_status[1]));
    end
  end

  assign bus.dout   = r_dout;
  assign bus.doe    = w_doe;
  assign bus.wait_n = (r_waitCnt == 3'd0);
  assign bus.int_n  = r_intN;
endmodule

// File: tb/tb_z80_io_responder.sv
// Self-checking bench for z80_io_responder: directed bus scenarios plus randomized
// register traffic checked against a register-map model held in the bench.
module tb_z80_io_responder;
  localparam int         TB_WAIT = 1;
  localparam logic [7:0] BASE    = 8'h40;
`ifdef Z80_IO_RESPONDER_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset_n;
  logic irq_in;
  int   nVec = 0;
  int   nErr = 0;
  int   cyc = 0;
  int   lastCommit = 0;
  logic [7:0] mReg [8];

  z80_io_responder_if bus();

  z80_io_responder #(.BASE_PORT(BASE), .WAIT_STATES(TB_WAIT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .irq_in(irq_in),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic busIdle();
    bus.A = 16'h0000; bus.di = 8'h00;
    bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.iorq_n = 1'b1;
    bus.rd_n = 1'b1; bus.wr_n = 1'b1;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) mReg[i] = 8'h00;
  endtask

  task automatic modelWrite(input logic [2:0] a, input logic [7:0] d);
    case (a)
      3'd0, 3'd1, 3'd6: mReg[a] = d;
      3'd2, 3'd3: mReg[a] = TIMER ? d : 8'h00;
      3'd4: mReg[4] = {6'b000000, d[1], TIMER ? d[0] : 1'b0};
      3'd5: mReg[5] = mReg[5] & ~{6'b000000, d[1:0]};
      default: ;
    endcase
  endtask

  function automatic logic [7:0] modelRead(input logic [2:0] a);
    return (a == 3'd7) ? 8'h5A : mReg[a];
  endfunction

  task automatic doReset();
    reset_n = 1'b0; busIdle(); irq_in = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    modelReset();
  endtask

  task automatic ioWrite(input logic [7:0] port, input logic [7:0] data, input bit raiseIrq,
                         output int waits, output int doeHi);
    bus.A = {8'($urandom), port}; bus.di = data;
    bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.rd_n = 1'b1;
    bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    waits = 0; doeHi = 0;
    while (bus.wait_n === 1'b0 && waits < 16) begin
      waits++;
      if (bus.doe !== 1'b0) doeHi++;
      tick();
    end
    if (bus.doe !== 1'b0) doeHi++;
    if (raiseIrq) irq_in = 1'b1;
    tick();
    lastCommit = cyc;
    bus.iorq_n = 1'b1; bus.wr_n = 1'b1;
    tick();
  endtask

  task automatic ioRead(input logic [7:0] port, output logic [7:0] data, output int waits,
                        output int doeHi, output int nSamp, output logic doeAfter);
    bus.A = {8'($urandom), port};
    bus.m1_n = 1'b1; bus.mreq_n = 1'b1; bus.wr_n = 1'b1;
    bus.iorq_n = 1'b0; bus.rd_n = 1'b0;
    tick();
    waits = 0; doeHi = 0; nSamp = 0;
    while (bus.wait_n === 1'b0 && waits < 16) begin
      waits++; nSamp++;
      if (bus.doe === 1'b1) doeHi++;
      tick();
    end
    nSamp++;
    if (bus.doe === 1'b1) doeHi++;
    data = bus.dout;
    bus.iorq_n = 1'b1; bus.rd_n = 1'b1;
    #1;
    doeAfter = bus.doe;
    tick();
  endtask

  task automatic test_reset();
    logic [7:0] d; int w, dh, ns; logic da;
    reset_n = 1'b0; busIdle(); irq_in = 1'b0;
    tick(); tick();
    nVec++; if (bus.dout !== 8'h00) begin nErr++; $display("[TB] FAIL reset_dout: got %h expected 00", bus.dout); end
    nVec++; if (bus.doe !== 1'b0) begin nErr++; $display("[TB] FAIL reset_doe: got %b expected 0", bus.doe); end
    nVec++; if (bus.wait_n !== 1'b1) begin nErr++; $display("[TB] FAIL reset_wait_n: got %b expected 1", bus.wait_n); end
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL reset_int_n: got %b expected 1", bus.int_n); end
    reset_n = 1'b1;
    tick();
    modelReset();
    for (int a = 0; a < 8; a++) begin
      ioRead(BASE | 8'(a), d, w, dh, ns, da);
      nVec++; if (d !== modelRead(3'(a))) begin nErr++; $display("[TB] FAIL reset_reg%0d: got %h expected %h", a, d, modelRead(3'(a))); end
    end
  endtask

  task automatic test_write_read();
    logic [7:0] d; int w, dh, ns; logic da;
    ioWrite(8'h41, 8'hA5, 1'b0, w, dh);
    modelWrite(3'd1, 8'hA5);
    nVec++; if (w != TB_WAIT) begin nErr++; $display("[TB] FAIL wr_waits: got %0d expected %0d", w, TB_WAIT); end
    nVec++; if (dh != 0) begin nErr++; $display("[TB] FAIL wr_doe: got %0d doe cycles expected 0", dh); end
    ioRead(8'h41, d, w, dh, ns, da);
    nVec++; if (d !== 8'hA5) begin nErr++; $display("[TB] FAIL rd_data: got %h expected a5", d); end
    nVec++; if (w != TB_WAIT) begin nErr++; $display("[TB] FAIL rd_waits: got %0d expected %0d", w, TB_WAIT); end
    nVec++; if (dh != ns) begin nErr++; $display("[TB] FAIL rd_doe_on: got %0d of %0d cycles expected all", dh, ns); end
    nVec++; if (da !== 1'b0) begin nErr++; $display("[TB] FAIL rd_doe_off: got %b expected 0", da); end
  endtask

  task automatic test_decode();
    logic [7:0] d; int w, dh, ns; logic da;
    ioWrite(8'h47, 8'h3C, 1'b0, w, dh);
    ioRead(8'h47, d, w, dh, ns, da);
    nVec++; if (d !== 8'h5A) begin nErr++; $display("[TB] FAIL id_read: got %h expected 5a", d); end
    ioWrite(8'h48, 8'h77, 1'b0, w, dh);
    nVec++; if (w != 0 || dh != 0) begin nErr++; $display("[TB] FAIL ign_wr: got waits=%0d doe=%0d expected 0/0", w, dh); end
    ioRead(8'h48, d, w, dh, ns, da);
    nVec++; if (w != 0 || dh != 0) begin nErr++; $display("[TB] FAIL ign_rd: got waits=%0d doe=%0d expected 0/0", w, dh); end
    bus.A = 16'h0040; bus.di = 8'h99;
    bus.m1_n = 1'b0; bus.mreq_n = 1'b0; bus.rd_n = 1'b0; bus.iorq_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      nVec++; if (bus.wait_n !== 1'b1 || bus.doe !== 1'b0) begin nErr++; $display("[TB] FAIL m1_ign: got wait_n=%b doe=%b expected 1/0", bus.wait_n, bus.doe); end
    end
    bus.m1_n = 1'b1; bus.rd_n = 1'b1; bus.wr_n = 1'b0;
    tick(); tick();
    busIdle();
    tick();
    ioRead(8'h40, d, w, dh, ns, da);
    nVec++; if (d !== modelRead(3'd0)) begin nErr++; $display("[TB] FAIL ign_nochange0: got %h expected %h", d, modelRead(3'd0)); end
    ioRead(8'h41, d, w, dh, ns, da);
    nVec++; if (d !== modelRead(3'd1)) begin nErr++; $display("[TB] FAIL ign_nochange1: got %h expected %h", d, modelRead(3'd1)); end
  endtask

  task automatic test_random();
    logic [7:0] d, p; int w, dh, ns; logic da;
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [2:0] a;
      logic [7:0] v;
      op = $urandom_range(0, 3);
      a  = 3'($urandom);
      v  = 8'($urandom);
      if (a == 3'd4) v = v & 8'hFE;
      case (op)
        0, 1: begin
          ioWrite(BASE | 8'(a), v, 1'b0, w, dh);
          modelWrite(a, v);
          nVec++; if (w != TB_WAIT) begin nErr++; $display("[TB] FAIL rnd_wr_waits: got %0d expected %0d", w, TB_WAIT); end
        end
        2: begin
          ioRead(BASE | 8'(a), d, w, dh, ns, da);
          nVec++; if (d !== modelRead(a) || dh != ns || da !== 1'b0) begin
            nErr++; $display("[TB] FAIL rnd_rd reg%0d: got %h doe=%0d/%0d expected %h doe all", a, d, dh, ns, modelRead(a));
          end
        end
        default: begin
          p = 8'($urandom);
          while ((p & 8'hF8) == (BASE & 8'hF8)) p = 8'($urandom);
          ioWrite(p, v, 1'b0, w, dh);
          nVec++; if (w != 0 || dh != 0) begin nErr++; $display("[TB] FAIL rnd_ign port %h: got waits=%0d doe=%0d expected 0/0", p, w, dh); end
        end
      endcase
    end
    for (int a = 0; a < 8; a++) begin
      ioRead(BASE | 8'(a), d, w, dh, ns, da);
      nVec++; if (d !== modelRead(3'(a))) begin nErr++; $display("[TB] FAIL rnd_final reg%0d: got %h expected %h", a, d, modelRead(3'(a))); end
    end
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL rnd_int_n: got %b expected 1", bus.int_n); end
  endtask

  task automatic test_irq_ack();
    logic [7:0] d; int w, dh, ns; logic da;
    doReset();
    ioWrite(8'h46, 8'hE0, 1'b0, w, dh);
    ioWrite(8'h44, 8'h02, 1'b0, w, dh);
    irq_in = 1'b1;
    tick();
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL irq_lag: got %b expected 1", bus.int_n); end
    tick();
    nVec++; if (bus.int_n !== 1'b0) begin nErr++; $display("[TB] FAIL irq_int_n: got %b expected 0", bus.int_n); end
    irq_in = 1'b0;
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h02) begin nErr++; $display("[TB] FAIL irq_status: got %h expected 02", d); end
    bus.m1_n = 1'b0; bus.iorq_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      nVec++; if (bus.dout !== 8'hE0 || bus.doe !== 1'b1) begin nErr++; $display("[TB] FAIL ack_vec: got dout=%h doe=%b expected e0/1", bus.dout, bus.doe); end
    end
    bus.m1_n = 1'b1; bus.iorq_n = 1'b1;
    #1;
    nVec++; if (bus.doe !== 1'b0) begin nErr++; $display("[TB] FAIL ack_doe_off: got %b expected 0", bus.doe); end
    tick();
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL ack_int_n: got %b expected 1", bus.int_n); end
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h00) begin nErr++; $display("[TB] FAIL ack_status: got %h expected 00", d); end
  endtask

  task automatic test_w1c_race();
    logic [7:0] d; int w, dh, ns; logic da;
    irq_in = 1'b1; tick(); tick(); irq_in = 1'b0; tick();
    ioWrite(8'h45, 8'h02, 1'b1, w, dh);
    irq_in = 1'b0;
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h02) begin nErr++; $display("[TB] FAIL w1c_race: got %h expected 02", d); end
    ioWrite(8'h45, 8'h02, 1'b0, w, dh);
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h00) begin nErr++; $display("[TB] FAIL w1c_clear: got %h expected 00", d); end
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL w1c_int_n: got %b expected 1", bus.int_n); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d; int w, dh, ns; logic da;
    irq_in = 1'b1; tick(); tick(); irq_in = 1'b0;
    nVec++; if (bus.int_n !== 1'b0) begin nErr++; $display("[TB] FAIL abort_pre_int: got %b expected 0", bus.int_n); end
    bus.A = 16'h0040; bus.di = 8'hC3; bus.iorq_n = 1'b0; bus.wr_n = 1'b0;
    tick();
    nVec++; if (bus.wait_n !== 1'b0) begin nErr++; $display("[TB] FAIL abort_in_wait: got %b expected 0", bus.wait_n); end
    reset_n = 1'b0;
    tick();
    nVec++; if (bus.wait_n !== 1'b1 || bus.doe !== 1'b0 || bus.int_n !== 1'b1) begin
      nErr++; $display("[TB] FAIL abort_outputs: got wait_n=%b doe=%b int_n=%b expected 1/0/1", bus.wait_n, bus.doe, bus.int_n);
    end
    busIdle();
    tick();
    reset_n = 1'b1;
    tick();
    modelReset();
    ioRead(8'h40, d, w, dh, ns, da);
    nVec++; if (d !== 8'h00) begin nErr++; $display("[TB] FAIL abort_reg: got %h expected 00", d); end
  endtask

`ifdef Z80_IO_RESPONDER_TIMER_EN
  task automatic test_timer();
    logic [7:0] d; int w, dh, ns; logic da;
    int c, f, dc, s;
    doReset();
    ioWrite(8'h42, 8'h03, 1'b0, w, dh);
    ioWrite(8'h43, 8'h00, 1'b0, w, dh);
    ioWrite(8'h44, 8'h03, 1'b0, w, dh);
    c = lastCommit;
    f = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.int_n === 1'b0) begin f = cyc; break; end
      tick();
    end
    nVec++; if (f - c != 5) begin nErr++; $display("[TB] FAIL tmr_first: got int_n low %0d clks after enable expected 5", f - c); end
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h01) begin nErr++; $display("[TB] FAIL tmr_status: got %h expected 01", d); end
    ioWrite(8'h45, 8'h01, 1'b0, w, dh);
    dc = lastCommit;
    s = c + 4 * ((dc - c + 3) / 4);
    f = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus.int_n === 1'b0) begin f = cyc; break; end
      tick();
    end
    nVec++; if (f != s + 1) begin nErr++; $display("[TB] FAIL tmr_period: got int_n low at %0d expected %0d", f, s + 1); end
  endtask
`else
  task automatic test_timer();
    logic [7:0] d; int w, dh, ns; logic da;
    doReset();
    ioWrite(8'h42, 8'h03, 1'b0, w, dh);
    ioWrite(8'h44, 8'h03, 1'b0, w, dh);
    for (int i = 0; i < 10; i++) tick();
    ioRead(8'h45, d, w, dh, ns, da);
    nVec++; if (d !== 8'h00) begin nErr++; $display("[TB] FAIL notmr_status: got %h expected 00", d); end
    ioRead(8'h44, d, w, dh, ns, da);
    nVec++; if (d !== 8'h02) begin nErr++; $display("[TB] FAIL notmr_ctrl: got %h expected 02", d); end
    ioRead(8'h42, d, w, dh, ns, da);
    nVec++; if (d !== 8'h00) begin nErr++; $display("[TB] FAIL notmr_reload: got %h expected 00", d); end
    nVec++; if (bus.int_n !== 1'b1) begin nErr++; $display("[TB] FAIL notmr_int_n: got %b expected 1", bus.int_n); end
  endtask
`endif

  initial begin
    reset_n = 1'b0;
    irq_in  = 1'b0;
    busIdle();
    modelReset();
    test_reset();
    test_write_read();
    test_decode();
    test_random();
    test_irq_ack();
    test_w1c_race();
    test_reset_abort();
    test_timer();
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
